// File: rtl/font_rom_arbiter_pkg.sv
// rtl/font_rom_arbiter_pkg.sv - shared types and helpers for the font ROM arbiter
// Holds the arbiter state type, the requester-count ceiling and the one-hot helper.
package font_rom_arb_pkg;

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} arb_state_t;

  localparam int MAX_REQ = 8;

  // One-hot vector with bit id set; zero when id is outside 0..n-1.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id, input int unsigned n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    if (id < n && id < MAX_REQ) v[id[2:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// rtl/font_rom_arbiter_if.sv - requester, response and ROM signals of the font ROM arbiter
// Ports (as signals): req_valid/req_addr/req_last in, req_ready out, rsp_valid/rsp_data out,
// rom_addr out to the ROM, rom_data back from the ROM. The slave modport is the arbiter side;
// the master modport is the environment (requesters plus the ROM).
interface font_rom_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int N_REQ = 3
);
  localparam int ADDRW = $clog2(DEPTH);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*ADDRW-1:0] req_addr;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic [ADDRW-1:0]       rom_addr;
  logic [WIDTH-1:0]       rom_data;

  modport slave (
    input  req_valid, req_addr, req_last, rom_data,
    output req_ready, rsp_valid, rsp_data, rom_addr
  );

  modport master (
    output req_valid, req_addr, req_last, rom_data,
    input  req_ready, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/font_rom_arbiter_rr_picker.sv
// rtl/font_rom_arbiter_rr_picker.sv - combinational round-robin winner search
// Ports: req_i request vector, ptr_i search start, prio0_i lets requester 0 win outright,
// grant_o winning index (0 when nothing requests), any_req_o set when any request is present.
module font_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic             prio0_i,
  output logic [IDW-1:0]   grant_o,
  output logic             any_req_o
);
  int   idx;
  logic found;

  always_comb begin
    grant_o   = '0;
    found     = 1'b0;
    idx       = 0;
    any_req_o = |req_i;
    // Priority requester 0 pre-empts the rotating search; grant_o already holds 0.
    if (prio0_i && req_i[0]) found = 1'b1;
    // Wrap modulo N_REQ, not modulo 2**IDW, so unused index codes are never visited.
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        grant_o = IDW'(idx);
        found   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - round-robin, burst-locking arbiter sharing one async font ROM
// Ports: clk, aresetn (async active-low), bus (slave modport: requests in, ready out,
// tagged responses out, ROM address out / ROM data in).
// Optional FONT_ROM_ARB_PRIO0_EN: requester 0 wins every arbitration it takes part in and the
// rotating pointer cycles over requesters 1..N_REQ-1 only; running bursts are never pre-empted.
import font_rom_arb_pkg::*;

module font_rom_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int N_REQ = 3
) (
  input logic               clk,
  input logic               aresetn,
  font_rom_arbiter_if.slave bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int IDW   = $clog2(N_REQ);

  localparam logic [0:0] ST_ARB   = 1'(ARB);
  localparam logic [0:0] ST_BURST = 1'(BURST);

`ifdef FONT_ROM_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [ADDRW-1:0] addr_q;
  logic [IDW-1:0]   id_q;
  logic             vld_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [IDW-1:0]   grant;
  logic             any_req;
  logic [N_REQ-1:0] ready;
  logic             accept;
  logic [IDW-1:0]   acc_id;
  logic             acc_last;
  logic [ADDRW-1:0] acc_addr;

  font_rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .prio0_i   (PRIO0),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  // Pointer value after requester w finishes; in priority mode requester 0 is skipped.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] w);
    if (PRIO0) return (w == IDW'(N_REQ - 1) || w == '0) ? IDW'(1) : w + IDW'(1);
    return (w == IDW'(N_REQ - 1)) ? '0 : w + IDW'(1);
  endfunction

  always_comb begin
    ready  = '0;
    acc_id = (state_q == ST_BURST) ? owner_q : grant;
    if (aresetn) begin
      if (state_q == ST_ARB) begin
        if (any_req) ready[grant] = 1'b1;
      end else begin
        // Locked: only the owner may move; a dropped valid simply idles the ROM.
        ready[owner_q] = bus.req_valid[owner_q];
      end
    end
    accept   = |ready;
    acc_last = bus.req_last[acc_id];
    acc_addr = bus.req_addr[int'(acc_id)*ADDRW +: ADDRW];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (accept) begin
      if (state_q == ST_ARB) begin
        if (acc_last) begin
          rr_ptr_d = next_ptr(grant);
        end else begin
          owner_d = grant;
          state_d = ST_BURST;
        end
      end else if (acc_last) begin
        rr_ptr_d = next_ptr(owner_q);
        state_d  = ST_ARB;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      vld_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      vld_q    <= accept;
      // addr_q doubles as rom_addr, so it only moves on an accepted beat.
      if (accept) begin
        addr_q <= acc_addr;
        id_q   <= acc_id;
      end
      rsp_valid_q <= vld_q ? N_REQ'(onehot(int'(id_q), N_REQ)) : '0;
      if (vld_q) rsp_data_q <= bus.rom_data;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rom_addr  = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - self-checking bench for font_rom_arbiter with a behavioural model
module tb_font_rom_arbiter;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  font_rom_arbiter_if #(.WIDTH(16), .DEPTH(256), .N_REQ(NR)) bus_if ();
  assign bus_if.rom_data = 16'hA500 | {8'h00, bus_if.rom_addr};

  font_rom_arbiter #(.WIDTH(16), .DEPTH(256), .N_REQ(NR)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural model: lock owner (-1 = none), rotating pointer, two-deep response delay.
  int          m_lock, m_ptr;
  bit          d1_v, d2_v;
  int          d1_id, d2_id;
  logic [7:0]  d1_a, d2_a, last_a;
  logic [15:0] exp_data;
  int          rsp_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v);
`ifdef FONT_ROM_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int nxt(input int w);
`ifdef FONT_ROM_ARB_PRIO0_EN
    return 1 + (w % (NR - 1));
`else
    return (w + 1) % NR;
`endif
  endfunction

  task automatic model_reset();
    m_lock = -1; m_ptr = 0; d1_v = 0; d2_v = 0; d1_id = 0; d2_id = 0;
    d1_a = 0; d2_a = 0; last_a = 0; exp_data = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] a, input bit l);
    bus_if.req_valid[i]       = v;
    bus_if.req_addr[i*8 +: 8] = a;
    bus_if.req_last[i]        = l;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'h00, 1'b1);
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic [NR-1:0] exp_ready, exp_rv;
    int acc;
    @(negedge clk);
    exp_ready = '0;
    acc = -1;
    if (m_lock >= 0) begin
      if (bus_if.req_valid[m_lock]) acc = m_lock;
    end else begin
      acc = pick(bus_if.req_valid);
    end
    if (acc >= 0) exp_ready[acc] = 1'b1;
    exp_rv = '0;
    if (d2_v) begin
      exp_rv[d2_id] = 1'b1;
      exp_data = 16'hA500 | {8'h00, d2_a};
    end
    chk("req_ready", 32'(bus_if.req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_rv));
    chk("rsp_data", 32'(bus_if.rsp_data), 32'(exp_data));
    chk("rom_addr", 32'(bus_if.rom_addr), 32'(last_a));
    if (bus_if.rsp_valid[1]) rsp_cnt1++;
    d2_v = d1_v; d2_id = d1_id; d2_a = d1_a;
    d1_v = (acc >= 0);
    if (acc >= 0) begin
      d1_id  = acc;
      d1_a   = bus_if.req_addr[acc*8 +: 8];
      last_a = d1_a;
      if (m_lock < 0) begin
        if (bus_if.req_last[acc]) m_ptr = nxt(acc);
        else m_lock = acc;
      end else if (bus_if.req_last[acc]) begin
        m_ptr  = nxt(m_lock);
        m_lock = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("reset_ready", 32'(bus_if.req_ready), 32'h0);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(bus_if.rsp_data), 32'h0);
    chk("reset_rom_addr", 32'(bus_if.rom_addr), 32'h0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t2_seq [6];
    logic [2:0] t3_next, t6_b;
    bit seen;
    model_reset();
    rsp_cnt1 = 0;
    idle_all();
    @(posedge clk);
    #1;
    do_reset();

    // 1: single read of 0x12 by requester 0.
    set_req(0, 1'b1, 8'h12, 1'b1);
    #1 chk("t1_ready", 32'(bus_if.req_ready), 32'h1);
    cycle();
    idle_all();
    #1 chk("t1_rom_addr", 32'(bus_if.rom_addr), 32'h12);
    cycle();
    #1 chk("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(bus_if.rsp_data), 32'hA512);
    cycle();

    // 2: three-way contention with single beats, starting from a fresh pointer.
    do_reset();
`ifdef FONT_ROM_ARB_PRIO0_EN
    t2_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    t2_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 8'(8'h20 + 8'(i*4 + r)), 1'b1);
      #1 chk("t2_grant", 32'(bus_if.req_ready), 32'(t2_seq[i]));
      cycle();
    end
    idle_all();
    cycle(); cycle();

    // 3: requester 1 bursts 0x40..0x4F while 0 and 2 keep requesting.
    rsp_cnt1 = 0;
    set_req(1, 1'b1, 8'h40, 1'b0);
    #1 chk("t3_first", 32'(bus_if.req_ready), 32'h2);
    cycle();
    for (int b = 1; b < 16; b++) begin
      set_req(0, 1'b1, 8'h01, 1'b1);
      set_req(2, 1'b1, 8'h02, 1'b1);
      set_req(1, 1'b1, 8'(8'h40 + b), b == 15);
      #1 chk("t3_locked", 32'(bus_if.req_ready), 32'h2);
      cycle();
    end
    set_req(1, 1'b0, 8'h00, 1'b1);
`ifdef FONT_ROM_ARB_PRIO0_EN
    t3_next = 3'b001;
`else
    t3_next = 3'b100;
`endif
    seen = 1'b0;
    for (int w = 0; w < 3 && !seen; w++) begin
      #1;
      if (bus_if.req_ready != 0) seen = 1'b1;
      else cycle();
    end
    chk("t3_after_burst", 32'(bus_if.req_ready), 32'(t3_next));
    cycle();
    idle_all();
    cycle(); cycle(); cycle();
    chk("t3_rsp_cnt_req1", 32'(rsp_cnt1), 32'd16);

    // 4: requester 2 stalls for three cycles mid-burst; the lock holds.
    set_req(2, 1'b1, 8'h80, 1'b0);
    cycle();
    set_req(2, 1'b1, 8'h81, 1'b0);
    cycle();
    set_req(2, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h05, 1'b1);
    set_req(1, 1'b1, 8'h06, 1'b1);
    for (int s = 0; s < 3; s++) begin
      #1 chk("t4_stall_ready", 32'(bus_if.req_ready), 32'h0);
      if (s == 2) chk("t4_stall_rsp", 32'(bus_if.rsp_valid), 32'h0);
      cycle();
    end
    set_req(2, 1'b1, 8'h82, 1'b0);
    #1 chk("t4_resume", 32'(bus_if.req_ready), 32'h4);
    cycle();
    set_req(2, 1'b1, 8'h83, 1'b1);
    #1 chk("t4_resume_last", 32'(bus_if.req_ready), 32'h4);
    cycle();
    idle_all();
    cycle(); cycle();

    // 6: requesters 0 and 1 both issue single beats continuously.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 8'h10, 1'b1);
      set_req(1, 1'b1, 8'h11, 1'b1);
`ifdef FONT_ROM_ARB_PRIO0_EN
      t6_b = 3'b001;
`else
      t6_b = (i % 2 == 0) ? 3'b001 : 3'b010;
`endif
      #1 chk("t6_grant", 32'(bus_if.req_ready), 32'(t6_b));
      cycle();
    end
    idle_all();
    cycle(); cycle();

    // 5: reset with two beats in flight; nothing may emerge afterwards.
    set_req(0, 1'b1, 8'h30, 1'b1);
    cycle();
    set_req(0, 1'b1, 8'h31, 1'b1);
    cycle();
    idle_all();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_no_rsp", 32'(bus_if.rsp_valid), 32'h0);
      cycle();
    end
    set_req(1, 1'b1, 8'h55, 1'b1);
    #1 chk("t5_req1_grant", 32'(bus_if.req_ready), 32'h2);
    cycle();
    idle_all();
    cycle(); cycle();

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NR; r++)
        set_req(r, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
